// File: rtl/rat_cycle_sequencer_if.sv
// Bundle between the RAT instruction-cycle sequencer and the decoder / PC / RAM / flag logic.
// STATE and PENDING are debug taps of the sequencer FSM and interrupt-pending latch.
interface rat_cycle_sequencer_if #(
  parameter int PC_W = 10
);
  logic            INT;
  logic            DEC_SEI;
  logic            DEC_CLI;
  logic            DEC_RETIE;
  logic            DEC_RETID;
  logic            RST_OUT;
  logic            PC_INC;
  logic            PC_LD_INT;
  logic [PC_W-1:0] PC_VEC;
  logic            EXEC_EN;
  logic            SCR_PUSH_PC;
  logic            FLG_SHAD_LD;
  logic            I_FLAG;
  logic            INT_ACK;
  logic [1:0]      STATE;
  logic            PENDING;

  modport master (
    output INT, DEC_SEI, DEC_CLI, DEC_RETIE, DEC_RETID,
    input  RST_OUT, PC_INC, PC_LD_INT, PC_VEC, EXEC_EN, SCR_PUSH_PC,
    input  FLG_SHAD_LD, I_FLAG, INT_ACK, STATE, PENDING
  );

  modport slave (
    input  INT, DEC_SEI, DEC_CLI, DEC_RETIE, DEC_RETID,
    output RST_OUT, PC_INC, PC_LD_INT, PC_VEC, EXEC_EN, SCR_PUSH_PC,
    output FLG_SHAD_LD, I_FLAG, INT_ACK, STATE, PENDING
  );
endinterface

// File: rtl/rat_cycle_sequencer.sv
// RAT MCU instruction-cycle sequencer: INIT/FETCH/EXEC/INTR FSM, I flag and interrupt-pending latch.
// Define RAT_INT_EDGE_EN for edge-triggered interrupts; default build is level-triggered.
module rat_cycle_sequencer #(
  parameter int              PC_W        = 10,
  parameter logic [PC_W-1:0] INT_VECTOR  = 10'h3FF,
  parameter int              SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  rat_cycle_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_INTR  = 2'b11
  } state_t;

  state_t                 state_q, state_d;
  logic                   i_flag_q, i_flag_d;
  logic                   pending_q, pending_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   int_sync;
  logic                   int_set;
  logic                   i_next;
  logic                   rst_out, pc_inc, exec_en, intr_seq;

  assign int_sync = sync_q[SYNC_STAGES-1];

`ifdef RAT_INT_EDGE_EN
  logic int_prev_q;

  always_ff @(posedge CLK) begin
    if (RESET) int_prev_q <= 1'b0;
    else       int_prev_q <= int_sync;
  end

  assign int_set = int_sync & ~int_prev_q;
`else
  assign int_set = int_sync;
`endif

  // A new request on the same edge as the entry clear must survive, so set dominates.
  assign pending_d = int_set | (pending_q & (state_q != ST_INTR));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_INIT;
      i_flag_q  <= 1'b0;
      pending_q <= 1'b0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      i_flag_q  <= i_flag_d;
      pending_q <= pending_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.INT};
    end
  end

  always_comb begin
    state_d  = state_q;
    i_flag_d = i_flag_q;
    i_next   = i_flag_q;
    rst_out  = 1'b0;
    pc_inc   = 1'b0;
    exec_en  = 1'b0;
    intr_seq = 1'b0;
    case (state_q)
      ST_INIT: begin
        rst_out = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        pc_inc  = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        exec_en = 1'b1;
        // Entry is decided on the post-instruction I value, so SEI admits and CLI blocks.
        if (bus.DEC_CLI || bus.DEC_RETID)      i_next = 1'b0;
        else if (bus.DEC_SEI || bus.DEC_RETIE) i_next = 1'b1;
        i_flag_d = i_next;
        state_d  = (pending_q && i_next) ? ST_INTR : ST_FETCH;
      end
      ST_INTR: begin
        intr_seq = 1'b1;
        i_flag_d = 1'b0;
        state_d  = ST_FETCH;
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign bus.RST_OUT     = rst_out;
  assign bus.PC_INC      = pc_inc;
  assign bus.EXEC_EN     = exec_en;
  assign bus.PC_LD_INT   = intr_seq;
  assign bus.SCR_PUSH_PC = intr_seq;
  assign bus.FLG_SHAD_LD = intr_seq;
  assign bus.INT_ACK     = intr_seq;
  assign bus.PC_VEC      = INT_VECTOR;
  assign bus.I_FLAG      = i_flag_q;
  assign bus.STATE       = state_q;
  assign bus.PENDING     = pending_q;

endmodule

// File: tb/tb_rat_cycle_sequencer.sv
// Directed testbench for rat_cycle_sequencer; expectations are hand-computed cycle by cycle.
module tb_rat_cycle_sequencer;

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_INTR  = 2'd3;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  rat_cycle_sequencer_if bus ();

  rat_cycle_sequencer dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge CLK);
  endtask

  task automatic set_dec(input logic [3:0] v);
    {bus.DEC_SEI, bus.DEC_CLI, bus.DEC_RETIE, bus.DEC_RETID} = v;
  endtask

  task automatic wait_exec(input string tag);
    int i;
    i = 0;
    while (bus.STATE !== S_EXEC && i < 8) begin
      step();
      i++;
    end
    n_cmp++;
    if (bus.STATE !== S_EXEC) begin
      n_err++;
      $display("FAIL %s_wait_exec: state %0d, want %0d", tag, bus.STATE, S_EXEC);
    end
  endtask

  // v = {sei, cli, retie, retid}; returns on the cycle after the EXEC edge.
  task automatic exec_instr(input string tag, input logic [3:0] v);
    wait_exec(tag);
    set_dec(v);
    step();
    set_dec(4'b0000);
  endtask

  task automatic test_reset();
    logic exp_rst, exp_inc, exp_ex;
    bus.INT = 1'b0;
    set_dec(4'b0000);
    RESET = 1'b1;
    repeat (3) step();
    n_cmp++; if (bus.STATE !== S_INIT) begin n_err++; $display("FAIL rst_state: got %0d want %0d", bus.STATE, S_INIT); end
    n_cmp++; if (bus.RST_OUT !== 1'b1) begin n_err++; $display("FAIL rst_rst_out: got %b want 1", bus.RST_OUT); end
    n_cmp++; if ({bus.PC_INC, bus.EXEC_EN, bus.PC_LD_INT, bus.SCR_PUSH_PC, bus.FLG_SHAD_LD, bus.INT_ACK} !== 6'b0) begin
      n_err++; $display("FAIL rst_strobes: got %b want 000000",
        {bus.PC_INC, bus.EXEC_EN, bus.PC_LD_INT, bus.SCR_PUSH_PC, bus.FLG_SHAD_LD, bus.INT_ACK});
    end
    n_cmp++; if (bus.I_FLAG !== 1'b0) begin n_err++; $display("FAIL rst_i_flag: got %b want 0", bus.I_FLAG); end
    n_cmp++; if (bus.PENDING !== 1'b0) begin n_err++; $display("FAIL rst_pending: got %b want 0", bus.PENDING); end
    n_cmp++; if (bus.PC_VEC !== 10'h3FF) begin n_err++; $display("FAIL rst_pc_vec: got %h want 3ff", bus.PC_VEC); end
    RESET = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      exp_rst = (c == 1);
      exp_inc = (c % 2 == 0);
      exp_ex  = (c % 2 == 1) && (c > 1);
      n_cmp++; if (bus.RST_OUT !== exp_rst) begin n_err++; $display("FAIL seq_rst_out c%0d: got %b want %b", c, bus.RST_OUT, exp_rst); end
      n_cmp++; if (bus.PC_INC !== exp_inc) begin n_err++; $display("FAIL seq_pc_inc c%0d: got %b want %b", c, bus.PC_INC, exp_inc); end
      n_cmp++; if (bus.EXEC_EN !== exp_ex) begin n_err++; $display("FAIL seq_exec_en c%0d: got %b want %b", c, bus.EXEC_EN, exp_ex); end
      n_cmp++; if (bus.I_FLAG !== 1'b0) begin n_err++; $display("FAIL seq_i_flag c%0d: got %b want 0", c, bus.I_FLAG); end
      step();
    end
  endtask

  task automatic test_sei_int();
    int acks, ack_at;
    acks = 0;
    ack_at = -1;
    exec_instr("sei_int", 4'b1000);
    n_cmp++; if (bus.I_FLAG !== 1'b1) begin n_err++; $display("FAIL sei_i_set: got %b want 1", bus.I_FLAG); end
    bus.INT = 1'b1;
    step();
    bus.INT = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.INT_ACK === 1'b1) begin
        acks++;
        if (ack_at < 0) ack_at = i;
        n_cmp++; if ({bus.SCR_PUSH_PC, bus.PC_LD_INT, bus.FLG_SHAD_LD} !== 3'b111) begin
          n_err++; $display("FAIL sei_int_entry_strobes: got %b want 111", {bus.SCR_PUSH_PC, bus.PC_LD_INT, bus.FLG_SHAD_LD});
        end
        n_cmp++; if (bus.PC_VEC !== 10'h3FF) begin n_err++; $display("FAIL sei_int_vec: got %h want 3ff", bus.PC_VEC); end
      end
      step();
    end
    n_cmp++; if (acks !== 1) begin n_err++; $display("FAIL sei_int_ack_count: got %0d want 1", acks); end
    n_cmp++; if (ack_at !== 3) begin n_err++; $display("FAIL sei_int_latency: got %0d want 3", ack_at); end
    n_cmp++; if (bus.I_FLAG !== 1'b0) begin n_err++; $display("FAIL sei_int_i_after: got %b want 0", bus.I_FLAG); end
    n_cmp++; if (bus.PENDING !== 1'b0) begin n_err++; $display("FAIL sei_int_pending_after: got %b want 0", bus.PENDING); end
  endtask

  task automatic test_masked_then_sei();
    int acks;
    acks = 0;
    bus.INT = 1'b1;
    step();
    bus.INT = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.INT_ACK === 1'b1) acks++;
      step();
    end
    n_cmp++; if (acks !== 0) begin n_err++; $display("FAIL masked_acks: got %0d want 0", acks); end
    n_cmp++; if (bus.PENDING !== 1'b1) begin n_err++; $display("FAIL masked_pending_held: got %b want 1", bus.PENDING); end
    exec_instr("masked", 4'b1000);
    n_cmp++; if (bus.STATE !== S_INTR) begin n_err++; $display("FAIL masked_sei_entry_state: got %0d want %0d", bus.STATE, S_INTR); end
    n_cmp++; if (bus.INT_ACK !== 1'b1) begin n_err++; $display("FAIL masked_sei_ack: got %b want 1", bus.INT_ACK); end
    step();
    n_cmp++; if (bus.PENDING !== 1'b0) begin n_err++; $display("FAIL masked_pending_cleared: got %b want 0", bus.PENDING); end
    n_cmp++; if (bus.I_FLAG !== 1'b0) begin n_err++; $display("FAIL masked_i_after: got %b want 0", bus.I_FLAG); end
  endtask

  task automatic test_flag_priority();
    logic [3:0] vecs [6];
    logic       exp_i [6];
    vecs  = '{4'b1000, 4'b1100, 4'b0010, 4'b0011, 4'b1010, 4'b1001};
    exp_i = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      exec_instr("flag_prio", vecs[k]);
      n_cmp++; if (bus.I_FLAG !== exp_i[k]) begin n_err++; $display("FAIL flag_prio v%b: got %b want %b", vecs[k], bus.I_FLAG, exp_i[k]); end
    end
  endtask

  task automatic test_cli_block();
    exec_instr("cli_block", 4'b1000);
    bus.INT = 1'b1;
    step();
    bus.INT = 1'b0;
    step();
    step();
    n_cmp++; if ({bus.STATE, bus.PENDING, bus.I_FLAG} !== {S_EXEC, 2'b11}) begin
      n_err++; $display("FAIL cli_block_pre: got st%0d p%b i%b want st%0d p1 i1", bus.STATE, bus.PENDING, bus.I_FLAG, S_EXEC);
    end
    set_dec(4'b0100);
    step();
    set_dec(4'b0000);
    n_cmp++; if (bus.STATE !== S_FETCH) begin n_err++; $display("FAIL cli_block_state: got %0d want %0d", bus.STATE, S_FETCH); end
    n_cmp++; if ({bus.PENDING, bus.I_FLAG} !== 2'b10) begin
      n_err++; $display("FAIL cli_block_flags: got p%b i%b want p1 i0", bus.PENDING, bus.I_FLAG);
    end
    exec_instr("cli_block_sei", 4'b1000);
    n_cmp++; if (bus.INT_ACK !== 1'b1) begin n_err++; $display("FAIL cli_block_sei_ack: got %b want 1", bus.INT_ACK); end
    step();
  endtask

  task automatic test_int_during_intr();
    exec_instr("during_intr", 4'b1000);
    bus.INT = 1'b1; step();
    bus.INT = 1'b0; step();
    bus.INT = 1'b1; step();
    bus.INT = 1'b0; step();
    n_cmp++; if ({bus.STATE, bus.INT_ACK} !== {S_INTR, 1'b1}) begin
      n_err++; $display("FAIL during_intr_ack1: got st%0d ack%b want st%0d ack1", bus.STATE, bus.INT_ACK, S_INTR);
    end
    step();
    n_cmp++; if ({bus.STATE, bus.PENDING, bus.I_FLAG} !== {S_FETCH, 2'b10}) begin
      n_err++; $display("FAIL during_intr_after_ack: got st%0d p%b i%b want st%0d p1 i0", bus.STATE, bus.PENDING, bus.I_FLAG, S_FETCH);
    end
    step();
    n_cmp++; if (bus.STATE !== S_EXEC) begin n_err++; $display("FAIL during_intr_exec: got %0d want %0d", bus.STATE, S_EXEC); end
    set_dec(4'b0010);
    step();
    set_dec(4'b0000);
    n_cmp++; if ({bus.STATE, bus.INT_ACK} !== {S_INTR, 1'b1}) begin
      n_err++; $display("FAIL during_intr_ack2: got st%0d ack%b want st%0d ack1", bus.STATE, bus.INT_ACK, S_INTR);
    end
    step();
    n_cmp++; if ({bus.PENDING, bus.I_FLAG} !== 2'b00) begin
      n_err++; $display("FAIL during_intr_final: got p%b i%b want p0 i0", bus.PENDING, bus.I_FLAG);
    end
  endtask

  task automatic test_reset_in_intr();
    int acks;
    acks = 0;
    exec_instr("rst_intr", 4'b1000);
    bus.INT = 1'b1; step();
    bus.INT = 1'b0; step();
    bus.INT = 1'b1; step();
    bus.INT = 1'b0; step();
    n_cmp++; if (bus.STATE !== S_INTR) begin n_err++; $display("FAIL rst_intr_in_intr: got %0d want %0d", bus.STATE, S_INTR); end
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    n_cmp++; if ({bus.STATE, bus.RST_OUT, bus.INT_ACK} !== {S_INIT, 2'b10}) begin
      n_err++; $display("FAIL rst_intr_state: got st%0d rst%b ack%b want st%0d rst1 ack0", bus.STATE, bus.RST_OUT, bus.INT_ACK, S_INIT);
    end
    n_cmp++; if ({bus.I_FLAG, bus.PENDING} !== 2'b00) begin
      n_err++; $display("FAIL rst_intr_flags: got i%b p%b want i0 p0", bus.I_FLAG, bus.PENDING);
    end
    step();
    n_cmp++; if ({bus.STATE, bus.PC_INC} !== {S_FETCH, 1'b1}) begin
      n_err++; $display("FAIL rst_intr_restart: got st%0d inc%b want st%0d inc1", bus.STATE, bus.PC_INC, S_FETCH);
    end
    for (int i = 0; i < 10; i++) begin
      if (bus.INT_ACK === 1'b1) acks++;
      step();
    end
    n_cmp++; if (acks !== 0) begin n_err++; $display("FAIL rst_intr_no_ack: got %0d want 0", acks); end
  endtask

  task automatic test_int_held();
    int acks, exp_acks, i;
`ifdef RAT_INT_EDGE_EN
    exp_acks = 0;
`else
    exp_acks = 30;
`endif
    acks = 0;
    exec_instr("held", 4'b1000);
    bus.INT = 1'b1;
    i = 0;
    while (bus.INT_ACK !== 1'b1 && i < 10) begin
      step();
      i++;
    end
    n_cmp++; if (bus.INT_ACK !== 1'b1) begin n_err++; $display("FAIL held_first_ack: got %b want 1", bus.INT_ACK); end
    for (int k = 0; k < 30; k++) begin
      exec_instr("held_retie", 4'b0010);
      if (bus.INT_ACK === 1'b1) acks++;
    end
    n_cmp++; if (acks !== exp_acks) begin n_err++; $display("FAIL held_reentries: got %0d want %0d", acks, exp_acks); end
    bus.INT = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    test_reset();
    test_sei_int();
    test_masked_then_sei();
    test_flag_priority();
    test_cli_block();
    test_int_during_intr();
    test_reset_in_intr();
    test_int_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
